// File: rtl/relogio_cfg.sv
// rtl/relogio_cfg.sv - HH:MM:SS clock core with 1 Hz prescaler, 12/24 h display, validated load
// Drives six 7-segment digits from registered BCD time state.
module relogio_cfg #(
   parameter int CLK_HZ         = 50_000_000,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int BLANK_H_MSD    = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       run,
   input  logic       mode_12h,
   input  logic       set_valid,
   input  logic [1:0] set_h_msd,
   input  logic [3:0] set_h_lsd,
   input  logic [2:0] set_m_msd,
   input  logic [3:0] set_m_lsd,
   input  logic [2:0] set_s_msd,
   input  logic [3:0] set_s_lsd,
   output logic       set_ack,
   output logic       set_err,
   output logic       sec_pulse,
   output logic       min_roll,
   output logic       hour_roll,
   output logic       day_roll,
   output logic       pm,
   output logic [6:0] s_lsd,
   output logic [6:0] s_msd,
   output logic [6:0] m_lsd,
   output logic [6:0] m_msd,
   output logic [6:0] h_lsd,
   output logic [6:0] h_msd
);

   localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

   logic [PW-1:0] presc;
   logic [3:0]    sec_lo, min_lo, hr_lo;
   logic [2:0]    sec_hi, min_hi;
   logic [1:0]    hr_hi;

   logic tick;
   logic set_ok;
   logic hour_ok;

   assign tick    = run && (presc == PRESC_MAX);
   assign hour_ok = ((set_h_msd < 2'd2) && (set_h_lsd <= 4'd9)) ||
                    ((set_h_msd == 2'd2) && (set_h_lsd <= 4'd3));
   assign set_ok  = hour_ok && (set_m_msd <= 3'd5) && (set_m_lsd <= 4'd9) &&
                    (set_s_msd <= 3'd5) && (set_s_lsd <= 4'd9);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         presc     <= '0;
         sec_lo    <= '0;
         sec_hi    <= '0;
         min_lo    <= '0;
         min_hi    <= '0;
         hr_lo     <= '0;
         hr_hi     <= '0;
         set_ack   <= 1'b0;
         set_err   <= 1'b0;
         sec_pulse <= 1'b0;
         min_roll  <= 1'b0;
         hour_roll <= 1'b0;
         day_roll  <= 1'b0;
      end else begin
         set_ack   <= 1'b0;
         set_err   <= 1'b0;
         sec_pulse <= 1'b0;
         min_roll  <= 1'b0;
         hour_roll <= 1'b0;
         day_roll  <= 1'b0;
         // A load request (good or bad) owns this cycle; any coincident tick is dropped.
         if (set_valid) begin
            if (set_ok) begin
               set_ack <= 1'b1;
               presc   <= '0;
               sec_lo  <= set_s_lsd;
               sec_hi  <= set_s_msd;
               min_lo  <= set_m_lsd;
               min_hi  <= set_m_msd;
               hr_lo   <= set_h_lsd;
               hr_hi   <= set_h_msd;
            end else begin
               set_err <= 1'b1;
            end
         end else if (run) begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
               sec_pulse <= 1'b1;
               if (sec_lo != 4'd9) begin
                  sec_lo <= sec_lo + 4'd1;
               end else begin
                  sec_lo <= 4'd0;
                  if (sec_hi != 3'd5) begin
                     sec_hi <= sec_hi + 3'd1;
                  end else begin
                     sec_hi   <= 3'd0;
                     min_roll <= 1'b1;
                     if (min_lo != 4'd9) begin
                        min_lo <= min_lo + 4'd1;
                     end else begin
                        min_lo <= 4'd0;
                        if (min_hi != 3'd5) begin
                           min_hi <= min_hi + 3'd1;
                        end else begin
                           min_hi    <= 3'd0;
                           hour_roll <= 1'b1;
                           if (hr_hi == 2'd2 && hr_lo == 4'd3) begin
                              hr_hi    <= 2'd0;
                              hr_lo    <= 4'd0;
                              day_roll <= 1'b1;
                           end else if (hr_lo == 4'd9) begin
                              hr_lo <= 4'd0;
                              hr_hi <= hr_hi + 2'd1;
                           end else begin
                              hr_lo <= hr_lo + 4'd1;
                           end
                        end
                     end
                  end
               end
            end
         end
      end
   end

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'h3F;
         4'd1:    p = 7'h06;
         4'd2:    p = 7'h5B;
         4'd3:    p = 7'h4F;
         4'd4:    p = 7'h66;
         4'd5:    p = 7'h6D;
         4'd6:    p = 7'h7D;
         4'd7:    p = 7'h07;
         4'd8:    p = 7'h7F;
         4'd9:    p = 7'h6F;
         default: p = 7'h00;
      endcase
      return (SEG_ACTIVE_LOW != 0) ? ~p : p;
   endfunction

   logic [4:0] hr_bin;
   logic [4:0] hr12;
   logic [3:0] disp_h_hi;
   logic [3:0] disp_h_lo;

   assign hr_bin = ({3'b000, hr_hi} * 5'd10) + {1'b0, hr_lo};
   assign pm     = (hr_bin >= 5'd12);

   // Display-only 12 h remap; internal time stays 24 h.
   always_comb begin
      hr12      = hr_bin;
      disp_h_hi = {2'b00, hr_hi};
      disp_h_lo = hr_lo;
      if (mode_12h) begin
         if (hr_bin == 5'd0) begin
            hr12 = 5'd12;
         end else if (hr_bin > 5'd12) begin
            hr12 = hr_bin - 5'd12;
         end
         if (hr12 >= 5'd10) begin
            disp_h_hi = 4'd1;
            disp_h_lo = 4'(hr12 - 5'd10);
         end else begin
            disp_h_hi = (BLANK_H_MSD != 0) ? 4'hF : 4'd0;
            disp_h_lo = 4'(hr12);
         end
      end
   end

   assign s_lsd = seg7(sec_lo);
   assign s_msd = seg7({1'b0, sec_hi});
   assign m_lsd = seg7(min_lo);
   assign m_msd = seg7({1'b0, min_hi});
   assign h_lsd = seg7(disp_h_lo);
   assign h_msd = seg7(disp_h_hi);

endmodule
